uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between two text-message sources, for example the result text buffer and a status/error message ROM.
- Each source raises a one-cycle request. The block arbitrates round-robin, reads the winner's buffer byte by byte, and drives each byte through the UART transmit handshake.
- A message ends at a NUL byte or at MAX_LEN bytes.
- Sits between the per-source text buffers and the uart instance in the top level. It replaces the ad hoc send FSM in the top level.

---
 rtl/uart_tx_arbiter_pkg.sv | 25 ++
 rtl/uart_tx_arbiter_rr_arb2.sv | 15 +
 rtl/uart_tx_arbiter.sv | 138 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter and the text buffers feeding it.
package uart_tx_arbiter_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StArb,
      StLoad,
      StFetch,
      StWait,
      StSend,
      StIncr,
      StFinish,
      StAbort
   } state_e;

   localparam logic [7:0] AsciiNul = 8'h00;
   localparam logic [7:0] AsciiSp  = 8'h20;
   localparam logic [7:0] AsciiCr  = 8'h0d;
   localparam logic [7:0] AsciiLf  = 8'h0a;

   function automatic logic [1:0] idx_to_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the one not served last.
module rr_arb2 (
   input  logic [1:0] pending_i,
   input  logic       last_grant_i,
   output logic [1:0] winner_o
);

   always_comb begin
      winner_o = pending_i;
      if (pending_i == 2'b11) begin
         winner_o = last_grant_i ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two NUL-terminated text sources, one message at a time.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned MaxLen     = 128,
   parameter int unsigned AddrW      = 8,
   parameter int unsigned TimeoutCyc = 1000000
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [1:0]       req_i,
   output logic             rd_sel_o,
   output logic [AddrW-1:0] rd_addr_o,
   input  logic [7:0]       rd_data_i,
   output logic             transmit_o,
   output logic [7:0]       tx_byte_o,
   input  logic             is_transmitting_i,
   output logic             busy_o,
   output logic [1:0]       grant_o,
   output logic [1:0]       done_o,
   output logic             timeout_err_o
);

   localparam int unsigned CntW = (TimeoutCyc > 1) ? $clog2(TimeoutCyc) : 1;

   state_e           state_q, state_d;
   logic [1:0]       pending_q, pending_d;
   logic             last_grant_q, last_grant_d;
   logic             rd_sel_q, rd_sel_d;
   logic [AddrW-1:0] rd_addr_q, rd_addr_d;
   logic [7:0]       tx_byte_q, tx_byte_d;
   logic [1:0]       grant_q, grant_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [1:0]       winner;

   rr_arb2 u_rr_arb2 (
      .pending_i    (pending_q),
      .last_grant_i (last_grant_q),
      .winner_o     (winner)
   );

   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q | req_i;
      last_grant_d = last_grant_q;
      rd_sel_d     = rd_sel_q;
      rd_addr_d    = rd_addr_q;
      tx_byte_d    = tx_byte_q;
      grant_d      = grant_q;
      cnt_d        = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (pending_q != 2'b00) state_d = StArb;
         end
         StArb: begin
            // A request from the winner in this same cycle survives and queues a re-send.
            pending_d    = (pending_q & ~winner) | req_i;
            last_grant_d = winner[1];
            rd_sel_d     = winner[1];
            rd_addr_d    = '0;
            grant_d      = winner;
            state_d      = StLoad;
         end
         StLoad: state_d = StFetch;
         StFetch: begin
            tx_byte_d = rd_data_i;
            if (rd_data_i == AsciiNul) begin
               state_d = StFinish;
            end else begin
               cnt_d   = '0;
               state_d = StWait;
            end
         end
         StWait: begin
            if (is_transmitting_i) begin
               state_d = StSend;
            end else if (cnt_q == CntW'(TimeoutCyc - 1)) begin
               state_d = StAbort;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StSend: begin
            if (!is_transmitting_i) state_d = StIncr;
         end
         StIncr: begin
            if (rd_addr_q == AddrW'(MaxLen - 1)) begin
               state_d = StFinish;
            end else begin
               rd_addr_d = rd_addr_q + 1'b1;
               state_d   = StLoad;
            end
         end
         StFinish, StAbort: begin
            grant_d = 2'b00;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         pending_q    <= 2'b00;
         last_grant_q <= 1'b1;
         rd_sel_q     <= 1'b0;
         rd_addr_q    <= '0;
         tx_byte_q    <= 8'h00;
         grant_q      <= 2'b00;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         last_grant_q <= last_grant_d;
         rd_sel_q     <= rd_sel_d;
         rd_addr_q    <= rd_addr_d;
         tx_byte_q    <= tx_byte_d;
         grant_q      <= grant_d;
         cnt_q        <= cnt_d;
      end
   end

   always_comb begin
      busy_o        = (state_q != StIdle);
      transmit_o    = (state_q == StWait);
      timeout_err_o = (state_q == StAbort);
      done_o        = ((state_q == StFinish) || (state_q == StAbort)) ? grant_q : 2'b00;
   end

   assign rd_sel_o  = rd_sel_q;
   assign rd_addr_o = rd_addr_q;
   assign tx_byte_o = tx_byte_q;

   logic unused_ascii;
   assign unused_ascii = ^{AsciiSp, AsciiCr, AsciiLf, idx_to_onehot(1'b0)};

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: text buffers, a UART busy model, and a message-level reference model.
module tb_uart_tx_arbiter;

   localparam int unsigned MaxLen = 128;
   localparam int unsigned TimeoutCyc = 50;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic [1:0] req_i = 2'b00;
   logic       rd_sel_o;
   logic [7:0] rd_addr_o;
   logic [7:0] rd_data_i;
   logic       transmit_o;
   logic [7:0] tx_byte_o;
   logic       is_transmitting_i;
   logic       busy_o;
   logic [1:0] grant_o;
   logic [1:0] done_o;
   logic       timeout_err_o;

   uart_tx_arbiter #(
      .MaxLen     (MaxLen),
      .AddrW      (8),
      .TimeoutCyc (TimeoutCyc)
   ) dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .req_i             (req_i),
      .rd_sel_o          (rd_sel_o),
      .rd_addr_o         (rd_addr_o),
      .rd_data_i         (rd_data_i),
      .transmit_o        (transmit_o),
      .tx_byte_o         (tx_byte_o),
      .is_transmitting_i (is_transmitting_i),
      .busy_o            (busy_o),
      .grant_o           (grant_o),
      .done_o            (done_o),
      .timeout_err_o     (timeout_err_o)
   );

   always #5 clk_i = ~clk_i;

   // Text buffers with one cycle of read latency.
   logic [7:0] mem [2][256];
   always @(posedge clk_i) rd_data_i <= mem[rd_sel_o][rd_addr_o];

   // UART model: takes a start strobe and stays busy for 10 cycles.
   int  ucnt;
   bit  uart_dead = 1'b0;
   always @(posedge clk_i) begin
      if (rst_i) ucnt <= 0;
      else if (ucnt != 0) ucnt <= ucnt - 1;
      else if (transmit_o && !uart_dead) ucnt <= 10;
   end
   assign is_transmitting_i = (ucnt != 0);

   // Monitor
   logic [7:0] tx_q[$];
   logic [1:0] done_q[$];
   bit  tx_prev = 1'b0;
   int  tx_hi_cnt, to_cnt, max_addr;
   bit  to_with_done;
   always @(negedge clk_i) begin
      if (transmit_o && !tx_prev) tx_q.push_back(tx_byte_o);
      tx_prev = transmit_o;
      if (transmit_o) tx_hi_cnt++;
      if (done_o != 2'b00) done_q.push_back(done_o);
      if (timeout_err_o) begin
         to_cnt++;
         to_with_done = (done_o == 2'b01);
      end
      if (busy_o && int'(rd_addr_o) > max_addr) max_addr = int'(rd_addr_o);
   end

   int n_tests = 0;
   int n_fail  = 0;
   bit model_last = 1'b1;

   task automatic clear_mon();
      tx_q.delete();
      done_q.delete();
      tx_hi_cnt    = 0;
      to_cnt       = 0;
      max_addr     = 0;
      to_with_done = 1'b0;
   endtask

   task automatic load_msg(input int s, input string str);
      for (int i = 0; i < str.len(); i++) mem[s][i] = str[i];
      mem[s][str.len()] = 8'h00;
   endtask

   task automatic pulse_req(input logic [1:0] r);
      @(negedge clk_i) req_i = r;
      @(negedge clk_i) req_i = 2'b00;
   endtask

   task automatic do_reset();
      @(negedge clk_i) rst_i = 1'b1;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      model_last = 1'b1;
      clear_mon();
   endtask

   task automatic wait_dones(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(posedge clk_i);
         if (done_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
      @(negedge clk_i);
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if ({busy_o, grant_o, done_o, timeout_err_o, transmit_o, rd_sel_o, rd_addr_o, tx_byte_o}
          !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b grant=%b done=%b terr=%b tx=%b sel=%b addr=%0d byte=%h, need all 0",
                  busy_o, grant_o, done_o, timeout_err_o, transmit_o, rd_sel_o, rd_addr_o,
                  tx_byte_o);
      end
   endtask

   task automatic test_single();
      bit ok;
      load_msg(0, "AB");
      clear_mon();
      pulse_req(2'b01);
      for (int c = 0; c < 500 && done_q.size() == 0; c++) @(negedge clk_i);
      n_tests++;
      if (done_q.size() != 1) begin
         n_fail++;
         $display("FAIL single_done_seen: got %0d done pulses, need 1", done_q.size());
      end
      @(negedge clk_i);
      n_tests++;
      if (busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL single_busy_after_done: got %b, need 0", busy_o);
      end
      repeat (50) @(negedge clk_i);
      ok = (tx_q.size() == 2) && (tx_q[0] == 8'h41) && (tx_q[1] == 8'h42);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL single_bytes: got %p, need 41 42", tx_q);
      end
      n_tests++;
      if (done_q.size() != 1 || done_q[0] !== 2'b01) begin
         n_fail++;
         $display("FAIL single_done: got %p, need exactly one 01", done_q);
      end
      model_last = 1'b0;
   endtask

   // Reference: both pending -> the source other than the last served goes first.
   task automatic test_both_pair(input string tag);
      bit ok;
      logic [7:0] exp_b[2];
      logic [1:0] exp_d[2];
      bit first;
      first = ~model_last;
      exp_b[0] = first ? 8'h59 : 8'h58;
      exp_b[1] = first ? 8'h58 : 8'h59;
      exp_d[0] = first ? 2'b10 : 2'b01;
      exp_d[1] = first ? 2'b01 : 2'b10;
      clear_mon();
      pulse_req(2'b11);
      wait_dones(2, 500, ok);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s_timeout: got %0d dones, need 2", tag, done_q.size());
      end
      n_tests++;
      if (tx_q.size() != 2 || tx_q[0] !== exp_b[0] || tx_q[1] !== exp_b[1]) begin
         n_fail++;
         $display("FAIL %s_bytes: got %p, need %h %h", tag, tx_q, exp_b[0], exp_b[1]);
      end
      n_tests++;
      if (done_q.size() != 2 || done_q[0] !== exp_d[0] || done_q[1] !== exp_d[1]) begin
         n_fail++;
         $display("FAIL %s_done_order: got %p, need %b %b", tag, done_q, exp_d[0], exp_d[1]);
      end
      model_last = ~first;
   endtask

   task automatic test_both();
      do_reset();
      load_msg(0, "X");
      load_msg(1, "Y");
      test_both_pair("both_first");
      test_both_pair("both_repeat");
   endtask

   task automatic test_no_nul();
      bit ok;
      for (int i = 0; i < 256; i++) mem[1][i] = 8'h30;
      clear_mon();
      pulse_req(2'b10);
      wait_dones(1, 5000, ok);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL nonul_timeout: got no done, need one");
      end
      n_tests++;
      if (tx_q.size() != MaxLen) begin
         n_fail++;
         $display("FAIL nonul_count: got %0d transmits, need %0d", tx_q.size(), MaxLen);
      end
      n_tests++;
      if (max_addr != MaxLen - 1) begin
         n_fail++;
         $display("FAIL nonul_last_addr: got %0d, need %0d", max_addr, MaxLen - 1);
      end
      n_tests++;
      if (done_q.size() != 1 || done_q[0] !== 2'b10) begin
         n_fail++;
         $display("FAIL nonul_done: got %p, need one 10", done_q);
      end
      model_last = 1'b1;
   endtask

   task automatic test_timeout();
      bit ok;
      uart_dead = 1'b1;
      load_msg(0, "Z");
      clear_mon();
      pulse_req(2'b01);
      wait_dones(1, 500, ok);
      n_tests++;
      if (tx_hi_cnt != TimeoutCyc) begin
         n_fail++;
         $display("FAIL timeout_tx_cycles: got %0d, need %0d", tx_hi_cnt, TimeoutCyc);
      end
      n_tests++;
      if (to_cnt != 1 || !to_with_done || done_q.size() != 1) begin
         n_fail++;
         $display("FAIL timeout_pulse: got terr=%0d with_done=%b dones=%0d, need 1 1 1",
                  to_cnt, to_with_done, done_q.size());
      end
      n_tests++;
      if (busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_idle: got busy=%b, need 0", busy_o);
      end
      uart_dead = 1'b0;
      model_last = 1'b0;
   endtask

   task automatic test_rerequest();
      bit ok;
      load_msg(0, "ABC");
      clear_mon();
      pulse_req(2'b01);
      for (int c = 0; c < 500 && tx_q.size() < 2; c++) @(posedge clk_i);
      pulse_req(2'b01);
      wait_dones(2, 1000, ok);
      repeat (30) @(negedge clk_i);
      n_tests++;
      if (tx_q.size() != 6 || tx_q[0] !== 8'h41 || tx_q[2] !== 8'h43 || tx_q[3] !== 8'h41
          || tx_q[5] !== 8'h43) begin
         n_fail++;
         $display("FAIL rereq_bytes: got %p, need 41 42 43 41 42 43", tx_q);
      end
      n_tests++;
      if (done_q.size() != 2) begin
         n_fail++;
         $display("FAIL rereq_done: got %0d dones, need 2", done_q.size());
      end
      model_last = 1'b0;
   endtask

   task automatic test_reset_mid();
      load_msg(0, "HELLO");
      load_msg(1, "Q");
      clear_mon();
      pulse_req(2'b01);
      for (int c = 0; c < 500 && tx_q.size() < 1; c++) @(posedge clk_i);
      pulse_req(2'b10);
      @(negedge clk_i) rst_i = 1'b1;
      @(negedge clk_i);
      n_tests++;
      if ({busy_o, grant_o, done_o, timeout_err_o, transmit_o, rd_sel_o, rd_addr_o, tx_byte_o}
          !== '0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got busy=%b grant=%b done=%b addr=%0d byte=%h, need 0",
                  busy_o, grant_o, done_o, rd_addr_o, tx_byte_o);
      end
      rst_i = 1'b0;
      model_last = 1'b1;
      clear_mon();
      repeat (300) @(negedge clk_i);
      n_tests++;
      if (tx_q.size() != 0 || done_q.size() != 0) begin
         n_fail++;
         $display("FAIL midreset_discard: got %0d bytes %0d dones, need 0 0",
                  tx_q.size(), done_q.size());
      end
   endtask

   task automatic test_random();
      bit ok;
      for (int it = 0; it < 6; it++) begin
         logic [7:0] msg[2][$];
         logic [7:0] exp_b[$];
         logic [1:0] exp_d[$];
         logic [1:0] p;
         for (int s = 0; s < 2; s++) begin
            int len;
            len = $urandom_range(0, 6);
            msg[s].delete();
            for (int i = 0; i < len; i++) begin
               mem[s][i] = 8'($urandom_range(1, 255));
               msg[s].push_back(mem[s][i]);
            end
            mem[s][len] = 8'h00;
         end
         p = 2'($urandom_range(1, 3));
         if (p == 2'b11) begin
            int a;
            a = model_last ? 0 : 1;
            exp_b = {msg[a], msg[1-a]};
            exp_d = {(a == 0) ? 2'b01 : 2'b10, (a == 0) ? 2'b10 : 2'b01};
            model_last = (a == 0);
         end else begin
            exp_b = msg[p[1]];
            exp_d = {p};
            model_last = p[1];
         end
         clear_mon();
         pulse_req(p);
         wait_dones(exp_d.size(), 1000, ok);
         repeat (5) @(negedge clk_i);
         n_tests++;
         if (tx_q != exp_b || done_q != exp_d) begin
            n_fail++;
            $display("FAIL random_%0d: got bytes %p dones %p, need bytes %p dones %p",
                     it, tx_q, done_q, exp_b, exp_d);
         end
      end
   endtask

   initial begin
      for (int s = 0; s < 2; s++) for (int i = 0; i < 256; i++) mem[s][i] = 8'h00;
      test_reset();
      test_single();
      test_both();
      test_no_nul();
      test_timeout();
      test_rerequest();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: bench did not finish, need completion");
      $fatal(1);
   end

endmodule
